chip8_mem_responder: RTL and testbench
======================================

# chip8_mem_responder

Memory-side responder for the CHIP-8 core's fetch/load/store port. It accepts one request at a time from the CPU: a 16-bit big-endian instruction fetch, a byte read or a byte write. It drives a single-port, synchronous-read, byte-wide RAM and returns exactly one response per request. It sits between the CPU and the 4 KiB program/data memory, and replaces direct combinational array indexing with a handshaked, latency-tolerant interface.

## Interface
- `ADDR_W`, 12, byte-address width.
- `MEM_BYTES`, 4096, implemented RAM size in bytes.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: the responder can accept a request.
- `req_addr` in ADDR_W: byte address.
- `req_we` in 1: 1 = byte write, 0 = read.
- `req_wide` in 1: for reads, 1 = 16-bit fetch of `{M[a], M[a+1]}`. Ignored when `req_we` = 1.
- `req_wdata` in 8: write byte.
- `rsp_valid` out 1: a response is presented.
- `rsp_ready` in 1: the CPU accepts the response.
- `rsp_data` out 16: the response data.
- `rsp_err` out 1: the request was out of range.
- `mem_en`, `mem_we` out 1: RAM enable and write enable.
- `mem_addr` out ADDR_W: RAM address.
- `mem_wdata` out 8: RAM write data.
- `mem_rdata` in 8: RAM read data, valid the cycle after the enable edge.

## Operation
- The FSM has four states: IDLE, RD_HI, RD_LO and RESP.
- `req_ready` = 1 only in IDLE. A request is accepted at a rising edge with `req_valid & req_ready`. Request fields are sampled at that edge only.
- In IDLE, `mem_*` are driven combinationally from the `req_*` inputs: `mem_en = req_valid`, and `mem_we = req_we` if the address is in range. The RAM acts on the acceptance edge.
- **Write:** IDLE → RESP. The response is `rsp_data` = 16'h0000, `rsp_err` = 0.
- **Byte read:** IDLE → RD_HI. In RD_HI, `mem_rdata` is captured into `rsp_data[7:0]` and `rsp_data[15:8]` = 8'h00. The FSM then moves RD_HI → RESP.
- **Wide read:** IDLE → RD_HI. In RD_HI, `mem_rdata` is captured into `rsp_data[15:8]`, and the read of a+1 is issued (`mem_en` = 1, `mem_addr` = a+1). The FSM moves RD_HI → RD_LO. In RD_LO, the low byte is captured and the FSM moves RD_LO → RESP.
- **RESP:** `rsp_valid` = 1, and `rsp_data`/`rsp_err` are held stable until `rsp_valid & rsp_ready`. The FSM then moves RESP → IDLE.
- **Range rule:** a request has `rsp_err` = 1 when:
  - `req_addr >= MEM_BYTES`, or
  - it is a wide read with `req_addr = MEM_BYTES-1`.
- **Behaviour on error:**
  - No RAM access is made for an out-of-range byte.
  - Missing bytes read as 8'h00.
  - Latency is unchanged.
  - A wide read at `MEM_BYTES-1` still returns the valid high byte.
- Address +1 is computed in ADDR_W bits. There is no wrap into address 0; the end-of-memory case is an error instead.
- `mem_en` = 0 and `mem_we` = 0 in RESP, and in every state not listed above.

## Timing
- Latency from the acceptance edge E0 to `rsp_valid` high:
  - write: 1 cycle (valid after E0),
  - byte read: 2 cycles (after E1),
  - wide read: 3 cycles (after E2).
- With `rsp_ready` held high, the next request can be accepted on the edge after the response handshake. Each accepted request spends one cycle in RESP plus any backpressure time.
- There is no pipelining: only one request is outstanding, and `req_ready` = 0 from E0 until RESP exits.
- Reset values: state = IDLE, `req_ready` = 0 while `rst_n` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_err` = 0, `mem_en` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- Reset mid-operation:
  - The FSM aborts to IDLE and the pending response is dropped.
  - A write already taken at E0 stays committed.
  - There is no spurious `rsp_valid` after reset.
- A `req_valid` that is held while `req_ready` = 0 must not be accepted twice.

## Structure
- `chip8_pkg` holds:
  - `ADDR_W` and `MEM_BYTES` defaults,
  - `PROG_START` = 12'h200,
  - `FONT_BASE` = 12'h000,
  - the responder state enum.
- Natural sub-module: `chip8_byte_ram`. It is a single-port synchronous RAM with `$readmemb` init and the ports `mem_en`/`mem_we`/`mem_addr`/`mem_wdata`/`mem_rdata`. The responder itself contains no storage array.

## Test plan
- **Wide fetch:** preload M[0x200]=8'hA2, M[0x201]=8'h2A. Request a wide read of 0x200 → `rsp_data` = 16'hA22A, `rsp_err` = 0, `rsp_valid` 3 cycles after acceptance.
- **Write then read:** byte write of 8'h5C to 0x3FF → response after 1 cycle. A byte read of 0x3FF then returns 16'h005C after 2 cycles.
- **End of memory:** wide read of 0xFFF with M[0xFFF]=8'h12 → `rsp_data` = 16'h1200, `rsp_err` = 1, and exactly one RAM enable is issued.
- **Backpressure:** hold `rsp_ready` = 0 for 5 cycles after `rsp_valid` → data is stable, `req_ready` = 0 throughout, and a pending `req_valid` is not accepted. Release → one handshake, then `req_ready` = 1 on the next cycle.
- **Reset mid-operation:** assert `rst_n` = 0 in RD_LO → all outputs reach their reset values asynchronously. After release, no `rsp_valid` appears until a new request.
- **Back-to-back:** eight wide fetches at 0x200, 0x202, … with `rsp_ready` = 1 → responses in order, each matching the preload, and no duplicate acceptances.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared constants and types for the CHIP-8 memory slice.
// Imported by the responder and the byte RAM.
package chip8_pkg;

  localparam int DEF_ADDR_W    = 12;
  localparam int DEF_MEM_BYTES = 4096;

  localparam logic [11:0] PROG_START = 12'h200;
  localparam logic [11:0] FONT_BASE  = 12'h000;

  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_RD_HI,
    RSP_RD_LO,
    RSP_RESP
  } rsp_state_e;

endpackage

// File: rtl/chip8_byte_ram.sv
// Single-port byte-wide RAM with synchronous read.
// Read data appears the cycle after an enabled edge.
module chip8_byte_ram
  import chip8_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MEM_BYTES = DEF_MEM_BYTES
) (
  input  logic              clk,
  input  logic              mem_en,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_wdata,
  output logic [7:0]        mem_rdata
);

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
      end
      mem_rdata <= mem[mem_addr];
    end
  end

endmodule

// File: rtl/chip8_mem_responder.sv
// Handshaked fetch/load/store responder for the CHIP-8 core.
// One request in flight; wide reads are split into two byte reads.
module chip8_mem_responder
  import chip8_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MEM_BYTES = DEF_MEM_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic              req_wide,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_data,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam logic [ADDR_W:0] MEM_END =
    (ADDR_W+1)'(MEM_BYTES);
  localparam logic [ADDR_W:0] EXT_ONE =
    (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] A_ONE =
    ADDR_W'(1);

  rsp_state_e        state_q;
  rsp_state_e        state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              wide_q;
  logic              hi_ok_q;
  logic              lo_ok_q;
  logic [15:0]       data_q;
  logic              err_q;

  logic [ADDR_W:0] req_ext;
  logic            hi_ok;
  logic            lo_ok;
  logic            is_wide;
  logic            accept;
  logic            hi_cap;
  logic            lo_cap;

  // Range checks run one bit wider so the end of memory cannot wrap.
  assign req_ext = {1'b0, req_addr};
  assign hi_ok   = req_ext < MEM_END;
  assign lo_ok   = (req_ext + EXT_ONE) < MEM_END;
  assign is_wide = req_wide & ~req_we;

  assign req_ready = rst_n & (state_q == RSP_IDLE);
  assign accept    = req_valid & req_ready;
  assign hi_cap    = state_q == RSP_RD_HI;
  assign lo_cap    = state_q == RSP_RD_LO;

  assign rsp_valid = state_q == RSP_RESP;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RSP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    unique case (state_q)
      RSP_IDLE: begin
        if (rst_n) begin
          mem_en    = req_valid & hi_ok;
          mem_we    = req_valid & req_we & hi_ok;
          mem_addr  = req_addr;
          mem_wdata = req_wdata;
        end
        if (accept) begin
          state_d = req_we ? RSP_RESP : RSP_RD_HI;
        end
      end
      RSP_RD_HI: begin
        if (wide_q) begin
          mem_en   = lo_ok_q;
          mem_addr = addr_q + A_ONE;
          state_d  = RSP_RD_LO;
        end else begin
          state_d = RSP_RESP;
        end
      end
      RSP_RD_LO: state_d = RSP_RESP;
      RSP_RESP: begin
        if (rsp_ready) begin
          state_d = RSP_IDLE;
        end
      end
      default: state_d = RSP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wide_q  <= 1'b0;
      hi_ok_q <= 1'b0;
      lo_ok_q <= 1'b0;
      data_q  <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      unique case (1'b1)
        accept: begin
          addr_q  <= req_addr;
          wide_q  <= is_wide;
          hi_ok_q <= hi_ok;
          lo_ok_q <= is_wide & lo_ok;
          data_q  <= 16'h0000;
          err_q   <= ~hi_ok | (is_wide & ~lo_ok);
        end
        hi_cap: begin
          if (wide_q) begin
            data_q[15:8] <= hi_ok_q ? mem_rdata : 8'h00;
          end else begin
            data_q <= {8'h00,
                       hi_ok_q ? mem_rdata : 8'h00};
          end
        end
        lo_cap: begin
          data_q[7:0] <= lo_ok_q ? mem_rdata : 8'h00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_mem_responder.sv
// Directed bench for the CHIP-8 memory responder with its byte RAM.
// RAM contents are preloaded through write requests.
module tb_chip8_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic        req_we;
  logic        req_wide;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int total;
  int bad;
  int en_cnt;
  int acc_cnt;

  logic [7:0] prog [16] = '{
    8'hA2, 8'h2A, 8'h60, 8'h0C,
    8'h61, 8'h05, 8'hD0, 8'h15,
    8'h70, 8'h01, 8'h12, 8'h00,
    8'hF0, 8'h29, 8'h00, 8'hE0
  };

  chip8_mem_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_wide  (req_wide),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  chip8_byte_ram ram (
    .clk       (clk),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && mem_en) en_cnt <= en_cnt + 1;
    if (rst_n && req_valid && req_ready)
      acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 12);
    chk("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic do_req(input logic we,
                        input logic wide,
                        input logic [11:0] addr,
                        input logic [7:0] wdata,
                        output logic [15:0] data,
                        output logic err,
                        output int lat);
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_we    = we;
    req_wide  = wide;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(lat);
    data = rsp_data;
    err  = rsp_err;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] d;
  logic        e;
  int          lat;
  int          snap;
  logic        seen;

  initial begin
    total = 0; bad = 0; en_cnt = 0; acc_cnt = 0;
    rst_n = 1'b0;
    req_valid = 1'b1;
    req_addr  = 12'h123;
    req_we    = 1'b1;
    req_wide  = 1'b0;
    req_wdata = 8'h99;
    rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 1);

    for (int i = 0; i < 16; i++) begin
      do_req(1'b1, 1'b0, 12'h200 + 12'(i),
             prog[i], d, e, lat);
      if (i == 0) begin
        chk("wr_lat", 32'(lat), 1);
        chk("wr_data", 32'(d), 0);
        chk("wr_err", 32'(e), 0);
      end
    end
    do_req(1'b1, 1'b0, 12'hFFF, 8'h12, d, e, lat);
    do_req(1'b1, 1'b0, 12'h300, 8'h44, d, e, lat);

    do_req(1'b0, 1'b1, 12'h200, 8'h00, d, e, lat);
    chk("fetch_data", 32'(d), 32'hA22A);
    chk("fetch_err", 32'(e), 0);
    chk("fetch_lat", 32'(lat), 3);

    do_req(1'b1, 1'b0, 12'h3FF, 8'h5C, d, e, lat);
    chk("wr3ff_lat", 32'(lat), 1);
    do_req(1'b0, 1'b0, 12'h3FF, 8'h00, d, e, lat);
    chk("rd3ff_data", 32'(d), 32'h005C);
    chk("rd3ff_err", 32'(e), 0);
    chk("rd3ff_lat", 32'(lat), 2);

    snap = en_cnt;
    do_req(1'b0, 1'b1, 12'hFFF, 8'h00, d, e, lat);
    chk("eom_data", 32'(d), 32'h1200);
    chk("eom_err", 32'(e), 1);
    chk("eom_lat", 32'(lat), 3);
    chk("eom_en_cnt", 32'(en_cnt - snap), 1);

    // Backpressure with a competing request held pending.
    @(negedge clk);
    snap = acc_cnt;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_wide  = 1'b0;
    req_addr  = 12'h201;
    @(posedge clk);
    #1;
    req_we    = 1'b1;
    req_addr  = 12'h300;
    req_wdata = 8'h77;
    wait_rsp(lat);
    for (int k = 0; k < 5; k++) begin
      chk("bp_data", 32'(rsp_data), 32'h002A);
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_req_ready", 32'(req_ready), 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("bp_ready_after", 32'(req_ready), 1);
    chk("bp_valid_after", 32'(rsp_valid), 0);
    chk("bp_acc", 32'(acc_cnt - snap), 1);
    do_req(1'b0, 1'b0, 12'h300, 8'h00, d, e, lat);
    chk("bp_no_write", 32'(d), 32'h0044);

    // Reset while the low byte of a fetch is in flight.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_wide  = 1'b1;
    req_addr  = 12'h202;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_req_ready", 32'(req_ready), 0);
    chk("mid_rsp_data", 32'(rsp_data), 0);
    chk("mid_rsp_err", 32'(rsp_err), 0);
    chk("mid_mem_en", 32'(mem_en), 0);
    chk("mid_mem_addr", 32'(mem_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("mid_no_spurious", 32'(seen), 0);
    chk("mid_ready", 32'(req_ready), 1);

    // Back-to-back fetches with req_valid held high throughout.
    snap = acc_cnt;
    rsp_ready = 1'b1;
    req_we    = 1'b0;
    req_wide  = 1'b1;
    req_addr  = 12'h200;
    req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      lat = 0;
      while (!req_ready && lat < 12) begin
        @(negedge clk);
        lat++;
      end
      chk("b2b_ready", 32'(req_ready), 1);
      @(posedge clk);
      #1;
      if (i == 7) req_valid = 1'b0;
      else req_addr = 12'h202 + 12'(2 * i);
      wait_rsp(lat);
      chk("b2b_data", 32'(rsp_data),
          32'({prog[2*i], prog[2*i+1]}));
      chk("b2b_err", 32'(rsp_err), 0);
    end
    @(posedge clk);
    repeat (3) @(negedge clk);
    chk("b2b_acc", 32'(acc_cnt - snap), 8);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
